// File: rtl/uart_boot_sequencer.sv
// uart_boot_sequencer: holds the CPU in reset while a framed image arrives
// over the UART byte stream and is written word-by-word into on-chip RAM.
// After a good checksum it releases the CPU and passes the memory bus through.
module uart_boot_sequencer #(
  parameter logic [31:0] RAM_BASE       = 32'h0001_0000,
  parameter logic [31:0] RAM_BYTES      = 32'd65536,
  parameter logic [31:0] MAGIC          = 32'h544F_4F42,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        boot_mode,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        cpu_mem_valid,
  input  logic [31:0] cpu_mem_addr,
  input  logic [31:0] cpu_mem_wdata,
  input  logic [3:0]  cpu_mem_wstrb,
  output logic        cpu_mem_ready,
  output logic [31:0] cpu_mem_rdata,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        cpu_reset_n,
  output logic        status_busy,
  output logic        status_done,
  output logic [1:0]  err_code
);

  typedef enum logic [3:0] {
    S_INIT      = 4'd0,
    S_HDR_MAGIC = 4'd1,
    S_HDR_ADDR  = 4'd2,
    S_HDR_LEN   = 4'd3,
    S_CHECK     = 4'd4,
    S_PAYLOAD   = 4'd5,
    S_WRITE     = 4'd6,
    S_CSUM      = 4'd7,
    S_DONE      = 4'd8
  } state_t;

  localparam logic [1:0]  ERR_NONE  = 2'd0;
  localparam logic [1:0]  ERR_RANGE = 2'd1;
  localparam logic [1:0]  ERR_TMO   = 2'd2;
  localparam logic [1:0]  ERR_CSUM  = 2'd3;
  // One past the last legal byte, kept 33 bits wide so the end check cannot wrap.
  localparam logic [32:0] RAM_END   = {1'b0, RAM_BASE} + {1'b0, RAM_BYTES};

  state_t      state_r, state_s;
  logic [1:0]  cnt_r, cnt_s;        // byte index within the current 4-byte field
  logic [31:0] word_r, word_s;      // little-endian assembly register
  logic [31:0] wptr_r, wptr_s;      // load address, then write pointer
  logic [31:0] remain_r, remain_s;  // length, then bytes still to write
  logic [7:0]  csum_r, csum_s;
  logic [31:0] idle_r, idle_s;
  logic [1:0]  err_r, err_s;
  logic        cpu_rst_n_r, cpu_rst_n_s;
  logic        byte_take_s;
  logic        idle_run_s;
  logic [31:0] word_shift_s;

  // Expected magic byte for position idx (byte 0 = bits 7:0).
  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    return MAGIC[{idx, 3'b000} +: 8];
  endfunction

  // Header legality: word alignment, non-empty, fully inside the RAM window.
  function automatic logic hdr_legal(input logic [31:0] addr, input logic [31:0] len);
    logic [32:0] end_v;
    end_v = {1'b0, addr} + {1'b0, len};
    return (addr[1:0] == 2'b00) && (len[1:0] == 2'b00) && (len != 32'd0) &&
           (addr >= RAM_BASE) && (end_v <= RAM_END);
  endfunction

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r     <= S_INIT;
      cnt_r       <= 2'd0;
      word_r      <= 32'd0;
      wptr_r      <= 32'd0;
      remain_r    <= 32'd0;
      csum_r      <= 8'd0;
      idle_r      <= 32'd0;
      err_r       <= ERR_NONE;
      cpu_rst_n_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      word_r      <= word_s;
      wptr_r      <= wptr_s;
      remain_r    <= remain_s;
      csum_r      <= csum_s;
      idle_r      <= idle_s;
      err_r       <= err_s;
      cpu_rst_n_r <= cpu_rst_n_s;
    end
  end

  // Next-state and datapath update, including the inter-byte timeout.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    word_s       = word_r;
    wptr_s       = wptr_r;
    remain_s     = remain_r;
    csum_s       = csum_r;
    idle_s       = idle_r;
    err_s        = err_r;
    cpu_rst_n_s  = cpu_rst_n_r;
    byte_take_s  = rx_valid && rx_ready;
    word_shift_s = {rx_data, word_r[31:8]};
    idle_run_s   = 1'b0;

    case (state_r)
      S_INIT: begin
        if (boot_mode) begin
          state_s = S_HDR_MAGIC;
        end else begin
          state_s     = S_DONE;
          cpu_rst_n_s = 1'b1;
        end
      end
      S_HDR_MAGIC: begin
        idle_run_s = (cnt_r != 2'd0);
        if (byte_take_s) begin
          if (rx_data == magic_byte(cnt_r)) begin
            if (cnt_r == 2'd3) begin
              state_s = S_HDR_ADDR;
              cnt_s   = 2'd0;
            end else begin
              cnt_s = cnt_r + 2'd1;
            end
          end else if (rx_data == MAGIC[7:0]) begin
            cnt_s = 2'd1;  // mismatching byte may itself start a new magic
          end else begin
            cnt_s = 2'd0;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      S_HDR_ADDR, S_HDR_LEN, S_PAYLOAD: begin
        idle_run_s = 1'b1;
        if (byte_take_s) begin
          word_s = word_shift_s;
          cnt_s  = cnt_r + 2'd1;
          if (state_r == S_PAYLOAD) begin
            csum_s = csum_r ^ rx_data;
          end else begin
            csum_s = csum_r;
          end
          if (cnt_r == 2'd3) begin
            case (state_r)
              S_HDR_ADDR: begin
                wptr_s  = word_shift_s;
                state_s = S_HDR_LEN;
              end
              S_HDR_LEN: begin
                remain_s = word_shift_s;
                state_s  = S_CHECK;
              end
              default: state_s = S_WRITE;
            endcase
          end else begin
            state_s = state_r;
          end
        end else begin
          word_s = word_r;
        end
      end
      S_CHECK: begin
        cnt_s = 2'd0;
        if (hdr_legal(wptr_r, remain_r)) begin
          state_s = S_PAYLOAD;
          csum_s  = 8'd0;
        end else begin
          state_s = S_HDR_MAGIC;
          err_s   = ERR_RANGE;
        end
      end
      S_WRITE: begin
        if (mem_ready) begin
          wptr_s   = wptr_r + 32'd4;
          remain_s = remain_r - 32'd4;
          if (remain_r == 32'd4) begin
            state_s = S_CSUM;
          end else begin
            state_s = S_PAYLOAD;
          end
        end else begin
          state_s = S_WRITE;
        end
      end
      S_CSUM: begin
        idle_run_s = 1'b1;
        if (byte_take_s) begin
          if (rx_data == csum_r) begin
            state_s     = S_DONE;
            cpu_rst_n_s = 1'b1;
            err_s       = ERR_NONE;
          end else begin
            state_s = S_HDR_MAGIC;
            cnt_s   = 2'd0;
            err_s   = ERR_CSUM;
          end
        end else begin
          state_s = S_CSUM;
        end
      end
      S_DONE: begin
        state_s = S_DONE;
      end
      default: begin
        state_s = S_INIT;
      end
    endcase

    // A byte arriving on the expiry cycle wins over the timeout.
    if (idle_run_s) begin
      if (byte_take_s) begin
        idle_s = 32'd0;
      end else if (idle_r >= (TIMEOUT_CYCLES - 32'd1)) begin
        idle_s  = 32'd0;
        err_s   = ERR_TMO;
        state_s = S_HDR_MAGIC;
        cnt_s   = 2'd0;
      end else begin
        idle_s = idle_r + 32'd1;
      end
    end else begin
      idle_s = 32'd0;
    end
  end

  // Outputs: byte handshake, status, and memory bus ownership mux.
  always_comb begin
    cpu_reset_n = cpu_rst_n_r;
    status_done = cpu_rst_n_r;
    err_code    = err_r;

    case (state_r)
      S_HDR_MAGIC, S_HDR_ADDR, S_HDR_LEN, S_PAYLOAD, S_CSUM: rx_ready = 1'b1;
      default: rx_ready = 1'b0;
    endcase

    case (state_r)
      S_HDR_MAGIC: status_busy = (cnt_r != 2'd0);
      S_HDR_ADDR, S_HDR_LEN, S_CHECK, S_PAYLOAD, S_WRITE, S_CSUM: status_busy = 1'b1;
      default: status_busy = 1'b0;
    endcase

    if (state_r == S_DONE) begin
      mem_valid     = cpu_mem_valid;
      mem_addr      = cpu_mem_addr;
      mem_wdata     = cpu_mem_wdata;
      mem_wstrb     = cpu_mem_wstrb;
      cpu_mem_ready = mem_ready;
      cpu_mem_rdata = mem_rdata;
    end else if (state_r == S_WRITE) begin
      mem_valid     = 1'b1;
      mem_addr      = wptr_r;
      mem_wdata     = word_r;
      mem_wstrb     = 4'hF;
      cpu_mem_ready = 1'b0;
      cpu_mem_rdata = 32'd0;
    end else begin
      mem_valid     = 1'b0;
      mem_addr      = 32'd0;
      mem_wdata     = 32'd0;
      mem_wstrb     = 4'h0;
      cpu_mem_ready = 1'b0;
      cpu_mem_rdata = 32'd0;
    end
  end

endmodule

// File: tb/tb_uart_boot_sequencer.sv
// Directed bench for uart_boot_sequencer with a small RAM adapter model.
module tb_uart_boot_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        boot_mode;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        cpu_mem_valid;
  logic [31:0] cpu_mem_addr;
  logic [31:0] cpu_mem_wdata;
  logic [3:0]  cpu_mem_wstrb;
  logic        cpu_mem_ready;
  logic [31:0] cpu_mem_rdata;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        cpu_reset_n;
  logic        status_busy;
  logic        status_done;
  logic [1:0]  err_code;

  logic        mem_rdy;
  logic [31:0] ram [0:63];
  int          wr_cnt = 0;
  int          vld_cnt = 0;
  int          total = 0;
  int          bad = 0;

  localparam logic [31:0] MAGIC_W = 32'h544F_4F42;

  always #5 clock = ~clock;

  assign mem_ready = mem_rdy;
  assign mem_rdata = ram[mem_addr[7:2]];

  uart_boot_sequencer #(.TIMEOUT_CYCLES(32'd100)) dut (
    .clock(clock), .reset_n(reset_n), .boot_mode(boot_mode),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .cpu_mem_valid(cpu_mem_valid), .cpu_mem_addr(cpu_mem_addr),
    .cpu_mem_wdata(cpu_mem_wdata), .cpu_mem_wstrb(cpu_mem_wstrb),
    .cpu_mem_ready(cpu_mem_ready), .cpu_mem_rdata(cpu_mem_rdata),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .cpu_reset_n(cpu_reset_n), .status_busy(status_busy),
    .status_done(status_done), .err_code(err_code)
  );

  // Memory adapter model: counts valid cycles and stores completed writes.
  always @(posedge clock) begin
    if (mem_valid) vld_cnt <= vld_cnt + 1;
    if (mem_valid && mem_ready && (mem_wstrb == 4'hF)) begin
      ram[mem_addr[7:2]] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 50) begin
      tick();
      n++;
    end
    chk("rx_ready_wait", 32'(rx_ready), 32'd1);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic send_header(input logic [31:0] a, input logic [31:0] l);
    send_word(MAGIC_W);
    send_word(a);
    send_word(l);
  endtask

  initial begin
    int w0;
    int v0;
    reset_n       = 1'b0;
    boot_mode     = 1'b1;
    rx_valid      = 1'b0;
    rx_data       = 8'h00;
    cpu_mem_valid = 1'b1;
    cpu_mem_addr  = 32'h0001_0004;
    cpu_mem_wdata = 32'hCAFE_F00D;
    cpu_mem_wstrb = 4'h0;
    mem_rdy       = 1'b1;
    tick();
    tick();

    // reset values, CPU request present but not forwarded
    chk("rst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_busy", 32'(status_busy), 32'd0);
    chk("rst_done", 32'(status_done), 32'd0);
    chk("rst_err", 32'(err_code), 32'd0);
    chk("rst_cpu_ready", 32'(cpu_mem_ready), 32'd0);

    reset_n = 1'b1;
    tick();
    chk("init_rx_ready", 32'(rx_ready), 32'd1);
    chk("init_busy", 32'(status_busy), 32'd0);

    // range: end beyond window
    v0 = vld_cnt;
    send_header(32'h0001_FFFC, 32'd8);
    tick();
    chk("range1_err", 32'(err_code), 32'd1);
    chk("range1_busy", 32'(status_busy), 32'd0);
    chk("range1_no_valid", 32'(vld_cnt - v0), 32'd0);

    // resync on magic, then stall inside the address field
    send_byte(8'h42);
    chk("resync_busy_a", 32'(status_busy), 32'd1);
    send_byte(8'h00);
    chk("resync_busy_b", 32'(status_busy), 32'd0);
    send_byte(8'h42);
    send_byte(8'h4F);
    send_byte(8'h4F);
    send_byte(8'h54);
    chk("resync_busy_c", 32'(status_busy), 32'd1);
    chk("resync_err", 32'(err_code), 32'd1);
    send_byte(8'h00);
    send_byte(8'h00);
    for (int i = 0; i < 99; i++) tick();
    chk("tmo_not_yet_err", 32'(err_code), 32'd1);
    chk("tmo_not_yet_busy", 32'(status_busy), 32'd1);
    tick();
    chk("tmo_err", 32'(err_code), 32'd2);
    chk("tmo_busy", 32'(status_busy), 32'd0);
    chk("tmo_rx_ready", 32'(rx_ready), 32'd1);

    // range: below RAM base
    send_header(32'h0000_FFFC, 32'd4);
    tick();
    chk("range2_err", 32'(err_code), 32'd1);

    // bad checksum frame: data still lands in RAM
    w0 = wr_cnt;
    send_header(32'h0001_0000, 32'd8);
    for (int i = 0; i < 4; i++) send_byte(8'(8'h11 * (i + 1)));
    chk("bad_w_valid", 32'(mem_valid), 32'd1);
    chk("bad_w_addr", mem_addr, 32'h0001_0000);
    chk("bad_w_data", mem_wdata, 32'h4433_2211);
    chk("bad_w_strb", 32'(mem_wstrb), 32'hF);
    chk("bad_w_cpu_ready", 32'(cpu_mem_ready), 32'd0);
    for (int i = 4; i < 8; i++) send_byte(8'(8'h11 * (i + 1)));
    send_byte(8'h00);
    chk("bad_err", 32'(err_code), 32'd3);
    chk("bad_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
    chk("bad_writes", 32'(wr_cnt - w0), 32'd2);
    chk("bad_ram0", ram[0], 32'h4433_2211);
    chk("bad_ram1", ram[1], 32'h8877_6655);

    // range: misaligned address
    send_header(32'h0001_0002, 32'd4);
    tick();
    chk("range3_err", 32'(err_code), 32'd1);

    // happy path with backpressure on the first word
    w0 = wr_cnt;
    send_header(32'h0001_0000, 32'd8);
    for (int i = 0; i < 3; i++) send_byte(8'(8'h11 * (i + 1)));
    mem_rdy = 1'b0;
    send_byte(8'h44);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 32'(mem_valid), 32'd1);
      chk("bp_addr", mem_addr, 32'h0001_0000);
      chk("bp_data", mem_wdata, 32'h4433_2211);
    end
    chk("bp_cpu_rdata_gated", cpu_mem_rdata, 32'd0);
    chk("bp_no_write", 32'(wr_cnt - w0), 32'd0);
    mem_rdy = 1'b1;
    tick();
    chk("bp_one_write", 32'(wr_cnt - w0), 32'd1);
    chk("bp_valid_drop", 32'(mem_valid), 32'd0);
    for (int i = 4; i < 8; i++) send_byte(8'(8'h11 * (i + 1)));
    send_byte(8'h88);
    chk("ok_cpu_reset_n", 32'(cpu_reset_n), 32'd1);
    chk("ok_done", 32'(status_done), 32'd1);
    chk("ok_err", 32'(err_code), 32'd0);
    chk("ok_rx_ready", 32'(rx_ready), 32'd0);
    chk("ok_busy", 32'(status_busy), 32'd0);
    chk("ok_writes", 32'(wr_cnt - w0), 32'd2);
    cpu_mem_addr = 32'h0001_0000;
    #1;
    chk("pt_mem_valid", 32'(mem_valid), 32'd1);
    chk("pt_mem_addr", mem_addr, 32'h0001_0000);
    chk("pt_mem_wdata", mem_wdata, 32'hCAFE_F00D);
    chk("pt_cpu_ready", 32'(cpu_mem_ready), 32'd1);
    chk("pt_cpu_rdata", cpu_mem_rdata, 32'h4433_2211);

    // reset from DONE
    reset_n = 1'b0;
    tick();
    chk("rd_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
    chk("rd_done", 32'(status_done), 32'd0);
    chk("rd_mem_valid", 32'(mem_valid), 32'd0);
    chk("rd_mem_addr", mem_addr, 32'd0);
    chk("rd_cpu_ready", 32'(cpu_mem_ready), 32'd0);
    reset_n = 1'b1;
    tick();

    // reset in the middle of a payload
    send_header(32'h0001_0002, 32'd4);
    tick();
    chk("mid_pre_err", 32'(err_code), 32'd1);
    send_header(32'h0001_0000, 32'd8);
    send_byte(8'hAA);
    send_byte(8'hBB);
    chk("mid_busy", 32'(status_busy), 32'd1);
    reset_n = 1'b0;
    tick();
    chk("mid_err", 32'(err_code), 32'd0);
    chk("mid_busy_rst", 32'(status_busy), 32'd0);
    chk("mid_rx_ready", 32'(rx_ready), 32'd0);
    chk("mid_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
    chk("mid_mem_valid", 32'(mem_valid), 32'd0);

    // boot_mode=0: CPU released on the first edge after reset
    boot_mode = 1'b0;
    cpu_mem_addr = 32'h0001_0004;
    tick();
    chk("nb_hold_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("nb_cpu_reset_n", 32'(cpu_reset_n), 32'd1);
    chk("nb_done", 32'(status_done), 32'd1);
    chk("nb_rx_ready", 32'(rx_ready), 32'd0);
    chk("nb_mem_addr", mem_addr, 32'h0001_0004);
    chk("nb_cpu_rdata", cpu_mem_rdata, 32'h8877_6655);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
